// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM states and host command opcodes.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_LOAD,
    OP_RUN,
    OP_RSVD
  } op_t;

endpackage

// File: rtl/counter_sequencer_carry.sv
// Rising-edge detector on the counter carry feeding a saturating tally,
// cleared at the start of a run and gated by a counting window.
module carry_edge_counter #(
  parameter int P_CARRY_BIT = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   carry,
  input  logic                   clr,
  input  logic                   window,
  output logic [P_CARRY_BIT-1:0] tally
);

  localparam logic [P_CARRY_BIT-1:0] TALLY_MAX = '1;

  logic carry_q;

  // carry_q tracks every cycle so an edge straddling the window start is not miscounted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      carry_q <= 1'b0;
      tally   <= '0;
    end else begin
      carry_q <= carry;
      if (clr) begin
        tally <= '0;
      end else if (window && carry && !carry_q && (tally != TALLY_MAX)) begin
        tally <= tally + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller for the up-counter: LOAD / RUN / NOP over valid/ready,
// runs the counter for exactly N cycles, supports abort, tallies carries, snapshots the count.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int P_BIT       = 4,
  parameter int P_RUN_BIT   = 8,
  parameter int P_CARRY_BIT = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [P_RUN_BIT-1:0]   cmd_data,
  input  logic                   abort,
  output logic                   enable,
  output logic                   wenable,
  output logic [P_BIT-1:0]       wcount,
  input  logic [P_BIT-1:0]       count,
  input  logic                   carry,
  output logic                   busy,
  output logic                   done,
  output logic [P_CARRY_BIT-1:0] carry_cnt,
  output logic [P_BIT-1:0]       last_count
);

  localparam logic [P_RUN_BIT-1:0] RUN_LAST = P_RUN_BIT'(1);

  state_t               state;
  logic [P_RUN_BIT-1:0] remaining;
  logic                 from_run;
  logic                 accept;
  logic                 run_start;
  logic                 tally_window;

  assign accept       = cmd_valid & cmd_ready;
  assign run_start    = accept && (op_t'(cmd_op) == OP_RUN) && (cmd_data != '0);
  assign tally_window = (state == ST_RUN) || ((state == ST_DONE) && from_run);

  // All host-visible outputs are registered from the next state so they change only on clk
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      from_run   <= 1'b0;
      cmd_ready  <= 1'b0;
      enable     <= 1'b0;
      wenable    <= 1'b0;
      wcount     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      last_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (accept) begin
            case (op_t'(cmd_op))
              OP_LOAD: begin
                state     <= ST_LOAD;
                wenable   <= 1'b1;
                wcount    <= cmd_data[P_BIT-1:0];
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              OP_RUN: begin
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
                if (cmd_data == '0) begin
                  state    <= ST_DONE;
                  done     <= 1'b1;
                  from_run <= 1'b0;
                end else begin
                  state     <= ST_RUN;
                  enable    <= 1'b1;
                  remaining <= cmd_data;
                end
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end

        ST_LOAD: begin
          state    <= ST_DONE;
          wenable  <= 1'b0;
          done     <= 1'b1;
          from_run <= 1'b0;
        end

        // Stopping at 1 rather than 0 keeps N = all-ones from needing a wider counter
        ST_RUN: begin
          remaining <= remaining - 1'b1;
          if (abort || (remaining == RUN_LAST)) begin
            state    <= ST_DONE;
            enable   <= 1'b0;
            done     <= 1'b1;
            from_run <= 1'b1;
          end
        end

        // The final enabled increment lands on the RUN exit edge, so count is sampled here
        ST_DONE: begin
          state     <= ST_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          from_run  <= 1'b0;
          if (from_run) begin
            last_count <= count;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  carry_edge_counter #(
    .P_CARRY_BIT(P_CARRY_BIT)
  ) u_carry (
    .clk   (clk),
    .resetn(resetn),
    .carry (carry),
    .clr   (run_start),
    .window(tally_window),
    .tally (carry_cnt)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer driving a behavioural up-counter; a second
// instance with a 2-bit carry tally shares the command stream to exercise saturation.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       abort;

  logic       cmd_ready, enable, wenable, busy, done, carry;
  logic [3:0] wcount, count, last_count;
  logic [7:0] carry_cnt;

  logic       cmd_ready2, enable2, wenable2, busy2, done2, carry2;
  logic [3:0] wcount2, count2, last_count2;
  logic [1:0] carry_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    op_t        op;
    logic [7:0] data;
    int         abort_at;
    int         exp_en;
    int         exp_we;
    int         exp_done_at;
    logic [3:0] exp_wcount;
    logic [3:0] exp_last;
    logic [7:0] exp_carry;
    logic [1:0] exp_carry2;
    logic [3:0] exp_count;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  counter_sequencer #(.P_BIT(4), .P_RUN_BIT(8), .P_CARRY_BIT(8)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .enable(enable),
    .wenable(wenable), .wcount(wcount), .count(count), .carry(carry),
    .busy(busy), .done(done), .carry_cnt(carry_cnt), .last_count(last_count)
  );

  counter_sequencer #(.P_BIT(4), .P_RUN_BIT(8), .P_CARRY_BIT(2)) dut2 (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .enable(enable2),
    .wenable(wenable2), .wcount(wcount2), .count(count2), .carry(carry2),
    .busy(busy2), .done(done2), .carry_cnt(carry_cnt2), .last_count(last_count2)
  );

  // Reference up-counter: carry is a one-cycle pulse following an enabled wrap
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 4'h0;
      carry <= 1'b0;
    end else begin
      carry <= enable && !wenable && (count == 4'hF);
      if (wenable) count <= wcount;
      else if (enable) count <= count + 4'h1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count2 <= 4'h0;
      carry2 <= 1'b0;
    end else begin
      carry2 <= enable2 && !wenable2 && (count2 == 4'hF);
      if (wenable2) count2 <= wcount2;
      else if (enable2) count2 <= count2 + 4'h1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input op_t op, input logic [7:0] data);
    @(negedge clk);
    for (int t = 0; t < 20 && !cmd_ready; t++) @(negedge clk);
    check("ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 8'h00;
  endtask

  task automatic check_output(input int idx, input vec_t v);
    int en_cnt = 0, we_cnt = 0, done_cnt = 0, done2_cnt = 0, done_at = 0;
    int ready_busy = 0, busy_seen = 0, both = 0;
    logic [3:0] we_val = 4'h0;
    string tag = $sformatf("v%0d", idx);
    apply_stimulus(v.op, v.data);
    for (int i = 1; i <= v.exp_en + 6; i++) begin
      @(negedge clk);
      if (enable) en_cnt++;
      if (wenable) begin
        we_cnt++;
        we_val = wcount;
      end
      if (enable && wenable) both++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
      if (done2) done2_cnt++;
      if (busy) busy_seen++;
      if (cmd_ready && busy) ready_busy++;
      abort = (v.abort_at != 0) && enable && (en_cnt == v.abort_at);
    end
    abort = 1'b0;
    check({tag, " enable_cycles"}, 32'(en_cnt), 32'(v.exp_en));
    check({tag, " wenable_cycles"}, 32'(we_cnt), 32'(v.exp_we));
    check({tag, " enable_with_wenable"}, 32'(both), 32'd0);
    check({tag, " done_pulses"}, 32'(done_cnt), (v.exp_done_at != 0) ? 32'd1 : 32'd0);
    check({tag, " done2_pulses"}, 32'(done2_cnt), (v.exp_done_at != 0) ? 32'd1 : 32'd0);
    check({tag, " done_cycle"}, 32'(done_at), 32'(v.exp_done_at));
    check({tag, " ready_while_busy"}, 32'(ready_busy), 32'd0);
    if (v.exp_we != 0) check({tag, " wcount_at_strobe"}, 32'(we_val), 32'(v.exp_wcount));
    if (v.exp_done_at == 0) check({tag, " busy_on_nop"}, 32'(busy_seen), 32'd0);
    check({tag, " wcount_hold"}, 32'(wcount), 32'(v.exp_wcount));
    check({tag, " last_count"}, 32'(last_count), 32'(v.exp_last));
    check({tag, " last_count2"}, 32'(last_count2), 32'(v.exp_last));
    check({tag, " carry_cnt"}, 32'(carry_cnt), 32'(v.exp_carry));
    check({tag, " carry_cnt_sat"}, 32'(carry_cnt2), 32'(v.exp_carry2));
    check({tag, " count"}, 32'(count), 32'(v.exp_count));
    check({tag, " count2"}, 32'(count2), 32'(v.exp_count));
    check({tag, " ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " busy2_after"}, 32'(busy2), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int en_cnt, done_cnt, ready_cnt, ready_busy;

    //           op       data   abt en   we done wc     last   carry  c2    count
    vecs[0]  = '{OP_LOAD, 8'hA5, 0,  0,   1, 2,   4'h5, 4'h0, 8'd0,  2'd0, 4'h5};
    vecs[1]  = '{OP_LOAD, 8'h00, 0,  0,   1, 2,   4'h0, 4'h0, 8'd0,  2'd0, 4'h0};
    vecs[2]  = '{OP_RUN,  8'd20, 0,  20,  0, 21,  4'h0, 4'h4, 8'd1,  2'd1, 4'h4};
    vecs[3]  = '{OP_RUN,  8'd0,  0,  0,   0, 1,   4'h0, 4'h4, 8'd1,  2'd1, 4'h4};
    vecs[4]  = '{OP_LOAD, 8'h3E, 0,  0,   1, 2,   4'hE, 4'h4, 8'd1,  2'd1, 4'hE};
    vecs[5]  = '{OP_RUN,  8'd3,  0,  3,   0, 4,   4'hE, 4'h1, 8'd1,  2'd1, 4'h1};
    vecs[6]  = '{OP_LOAD, 8'h0F, 0,  0,   1, 2,   4'hF, 4'h1, 8'd1,  2'd1, 4'hF};
    vecs[7]  = '{OP_RUN,  8'd1,  0,  1,   0, 2,   4'hF, 4'h0, 8'd1,  2'd1, 4'h0};
    vecs[8]  = '{OP_RUN,  8'd100,10, 10,  0, 11,  4'hF, 4'hA, 8'd0,  2'd0, 4'hA};
    vecs[9]  = '{OP_LOAD, 8'h00, 0,  0,   1, 2,   4'h0, 4'hA, 8'd0,  2'd0, 4'h0};
    vecs[10] = '{OP_RUN,  8'd80, 0,  80,  0, 81,  4'h0, 4'h0, 8'd5,  2'd3, 4'h0};
    vecs[11] = '{OP_RUN,  8'd255,0,  255, 0, 256, 4'h0, 4'hF, 8'd15, 2'd3, 4'hF};
    vecs[12] = '{OP_NOP,  8'h55, 0,  0,   0, 0,   4'h0, 4'hF, 8'd15, 2'd3, 4'hF};
    vecs[13] = '{OP_RSVD, 8'h12, 0,  0,   0, 0,   4'h0, 4'hF, 8'd15, 2'd3, 4'hF};
    vecs[14] = '{OP_RUN,  8'd3,  0,  3,   0, 4,   4'h0, 4'h3, 8'd0,  2'd0, 4'h3};

    resetn    = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 8'h00;
    abort     = 1'b0;
    #3 resetn = 1'b0;

    repeat (2) @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset enable", 32'(enable), 32'd0);
    check("reset wenable", 32'(wenable), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset wcount", 32'(wcount), 32'd0);
    check("reset carry_cnt", 32'(carry_cnt), 32'd0);
    check("reset last_count", 32'(last_count), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("release cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 14; i++) check_output(i, vecs[i]);

    // cmd_valid held high with RUN 2: accept, 2 enables, done, one idle cycle, repeat
    @(negedge clk);
    for (int t = 0; t < 20 && !cmd_ready; t++) @(negedge clk);
    check("b2b ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    cmd_data  = 8'd2;
    @(posedge clk);
    en_cnt = 0; done_cnt = 0; ready_cnt = 0; ready_busy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (enable) en_cnt++;
      if (done) done_cnt++;
      if (cmd_ready) ready_cnt++;
      if (cmd_ready && busy) ready_busy++;
    end
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 8'h00;
    check("b2b enable_cycles", 32'(en_cnt), 32'd10);
    check("b2b done_pulses", 32'(done_cnt), 32'd5);
    check("b2b ready_cycles", 32'(ready_cnt), 32'd5);
    check("b2b ready_while_busy", 32'(ready_busy), 32'd0);
    repeat (3) @(negedge clk);
    check("b2b idle_after", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a long run
    apply_stimulus(OP_RUN, 8'd50);
    repeat (10) @(negedge clk);
    check("midrun enable_before", 32'(enable), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrun enable", 32'(enable), 32'd0);
    check("midrun busy", 32'(busy), 32'd0);
    check("midrun done", 32'(done), 32'd0);
    check("midrun cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("midrun held cmd_ready", 32'(cmd_ready), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("midrun release cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrun release carry_cnt", 32'(carry_cnt), 32'd0);
    check("midrun release last_count", 32'(last_count), 32'd0);
    check("midrun release wcount", 32'(wcount), 32'd0);
    check_output(14, vecs[14]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
